inst_loader: RTL and testbench
==============================

# inst_loader

Synthesizable program loader that fills the processor's instruction RAM from a byte stream and then releases the core from reset. It drives the same instruction-write port the bench drives (Ram_Inst_Write, Inst_Addr, Ram_Inst_In), sequencing addresses 0..NUM_MEM_ADDR-1. While loading it holds the processor in reset, and it deasserts that reset only after the last word is written. It sits between the board-level byte source (UART/SPI front end) and the PROCESSOR top.

## Interface
- INST_WIDTH, 16, instruction word width; matches the processor's `INST_WIDTH`.
- ADDR_WIDTH, 8, instruction address width; matches `ADDR_WIDTH`.
- NUM_MEM_ADDR, 256, number of words loaded; must be ≤ 2^ADDR_WIDTH and ≥ 1.
- Derived parameter: BYTES_PER_INST = ceil(INST_WIDTH/8).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low.
- Start  in  1  single-cycle load request.
- Byte_In  in  8  stream data.
- Byte_Valid  in  1  Byte_In is valid.
- Byte_Ready  out  1  loader accepts a byte this cycle.
- Ram_Inst_Write  out  1  instruction RAM write strobe.
- Inst_Addr  out  ADDR_WIDTH  write address.
- Ram_Inst_In  out  INST_WIDTH  write data.
- Core_Reset  out  1  active-high reset to PROCESSOR.
- Busy  out  1  load in progress.
- Done  out  1  load complete and core running.
- Err  out  1  checksum failure; tied 0 when the feature is compiled out.

## Operation
- States: IDLE, COLLECT, WRITE, CHECK (only with the feature enabled), DONE, ERROR.
- Reset (Reset=0), effective immediately and from any state:
  - State goes to IDLE.
  - Core_Reset=1.
  - Ram_Inst_Write=0, Inst_Addr=0, Ram_Inst_In=0.
  - Byte_Ready=0, Busy=0, Done=0, Err=0.
  - Byte counter and checksum accumulator cleared.
- IDLE:
  - Outputs hold their reset values.
  - Start=1 moves to COLLECT with Inst_Addr=0 and Core_Reset=1.
- COLLECT:
  - Byte_Ready=1 and Busy=1.
  - A byte is accepted when Byte_Valid & Byte_Ready.
  - Each accepted byte is shifted into Ram_Inst_In from the LSB side, so bytes arrive MSB first.
  - When INST_WIDTH is not a multiple of 8, only the low INST_WIDTH bits are kept and excess high bits of the first byte are dropped.
  - Acceptance of byte BYTES_PER_INST moves to WRITE.
- WRITE:
  - Ram_Inst_Write=1 for exactly one cycle; Byte_Ready=0.
  - Inst_Addr and Ram_Inst_In are stable for that cycle.
  - If Inst_Addr == NUM_MEM_ADDR-1, the next state is CHECK (feature enabled) or DONE (feature disabled).
  - Otherwise Inst_Addr increments and the state returns to COLLECT.
- DONE:
  - Core_Reset=0, Done=1, Busy=0, Byte_Ready=0.
  - Inst_Addr holds the last address.
  - Start=1 restarts: Core_Reset=1 and Done=0 on the next cycle, Inst_Addr=0, state goes to COLLECT.
- ERROR:
  - Core_Reset=1, Err=1, Busy=0.
  - Start=1 restarts as from DONE and clears Err.
- Start is ignored in COLLECT, WRITE and CHECK.
- Byte_Valid while Byte_Ready=0 is ignored; the source holds the byte until it is accepted.

## Timing
- Last byte of a word accepted in cycle k:
  - Ram_Inst_Write=1 in cycle k+1.
  - Inst_Addr shows the next address in cycle k+2.
  - Byte_Ready=1 again in cycle k+2.
- Peak throughput: one word per BYTES_PER_INST+1 cycles.
- Final WRITE in cycle w: Core_Reset falls and Done rises in cycle w+1 (feature disabled).
- Start seen in cycle s: Busy=1 and Byte_Ready=1 in cycle s+1.
- Reset assertion mid-load aborts immediately: a partial word is never written and Core_Reset stays 1.
- Ram_Inst_Write is never asserted outside WRITE.

## Configuration
- Macro: `LOADER_CHECKSUM_EN`.
- Defined:
  - An 8-bit accumulator sums every accepted byte mod 256, including the trailer.
  - After the final WRITE the loader enters CHECK with Byte_Ready=1 and accepts one trailer byte.
  - On acceptance, the next state is DONE if the sum is 8'h00, otherwise ERROR.
  - Core_Reset is released only on a passing checksum.
- Not defined:
  - The CHECK state and the accumulator are absent.
  - Err is tied 0.
  - The final WRITE goes directly to DONE.

## Test plan
Bench parameters: INST_WIDTH=16, NUM_MEM_ADDR=4.
- Reset low then high, no Start: Core_Reset=1, Ram_Inst_Write=0, Inst_Addr=0, Byte_Ready=0 for 20 cycles.
- Start, then bytes 12 34 56 78 9A BC DE F0 with Byte_Valid held high:
  - Writes 1234@0, 5678@1, 9ABC@2, DEF0@3, each with exactly one write strobe.
  - Core_Reset falls and Done=1 one cycle after the 4th write.
- Same stream with Byte_Valid gapped randomly:
  - Identical write sequence.
  - No write before both bytes of a word are accepted.
- Reset pulled low after 3 bytes:
  - Outputs return to reset values immediately.
  - A new Start plus 8 bytes writes correctly starting at address 0.
- In DONE, pulse Start: Core_Reset=1 and Done=0 next cycle; a reload overwrites addresses 0–3.
- `LOADER_CHECKSUM_EN`, bytes 12 34 56 78 9A BC DE F0 (sum 8'h38):
  - Trailer C8 gives Done=1 and Core_Reset=0.
  - Trailer C9 gives Err=1 and Core_Reset stays 1.

Source files
------------

// File: rtl/inst_loader_if.sv
// Byte-stream / instruction-RAM write bus between the program loader and its environment.
interface inst_loader_if #(
    parameter int unsigned INST_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                  Start;
    logic [7:0]            Byte_In;
    logic                  Byte_Valid;
    logic                  Byte_Ready;
    logic                  Ram_Inst_Write;
    logic [ADDR_WIDTH-1:0] Inst_Addr;
    logic [INST_WIDTH-1:0] Ram_Inst_In;
    logic                  Core_Reset;
    logic                  Busy;
    logic                  Done;
    logic                  Err;

    // Loader side: consumes the byte stream, drives the RAM port and core control.
    modport master (
        input  Start, Byte_In, Byte_Valid,
        output Byte_Ready, Ram_Inst_Write, Inst_Addr, Ram_Inst_In,
        output Core_Reset, Busy, Done, Err
    );

    // Environment side: byte source plus RAM/processor observers.
    modport slave (
        output Start, Byte_In, Byte_Valid,
        input  Byte_Ready, Ram_Inst_Write, Inst_Addr, Ram_Inst_In,
        input  Core_Reset, Busy, Done, Err
    );
endinterface

// File: rtl/inst_loader.sv
// Program loader: assembles MSB-first bytes into instruction words, writes them
// to addresses 0..NUM_MEM_ADDR-1, then releases the processor from reset.
// Optional trailer checksum enabled by defining LOADER_CHECKSUM_EN.
module inst_loader #(
    parameter int unsigned INST_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned NUM_MEM_ADDR = 256
) (
    input  logic          Clk,
    input  logic          Reset,
    inst_loader_if.master bus
);

    localparam int unsigned BYTES_PER_INST = (INST_WIDTH + 7) / 8;
    localparam int unsigned CNT_W          = (BYTES_PER_INST > 1) ? $clog2(BYTES_PER_INST) : 1;
    localparam logic [CNT_W-1:0]      LAST_BYTE = CNT_W'(BYTES_PER_INST - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_MEM_ADDR - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WRITE   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK   = 3'd3,
`endif
        S_DONE    = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [INST_WIDTH-1:0] data_q, data_d;

    logic ready_q, ready_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic core_rst_q, core_rst_d;
    logic wr_q, wr_d;
    logic err_d;

    logic accept;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
    logic       err_q;
`endif

    // Handshake uses the registered ready so a byte is taken only when advertised.
    assign accept = bus.Byte_Valid & ready_q;

    // State register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, datapath next values and registered-output next values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        ready_d    = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        core_rst_d = 1'b1;
        wr_d       = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (bus.Start) begin
                    state_d = S_COLLECT;
                    addr_d  = '0;
                    cnt_d   = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            S_COLLECT: begin
                if (accept) begin
                    // Shift in from the LSB side; excess high bits fall off the top.
                    data_d = INST_WIDTH'({data_q, bus.Byte_In});
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q + bus.Byte_In;
`endif
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d   = '0;
                        state_d = S_WRITE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_WRITE: begin
                if (addr_q == LAST_ADDR) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    state_d = S_COLLECT;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) begin
                    csum_d  = csum_q + bus.Byte_In;
                    state_d = (csum_d == 8'h00) ? S_DONE : S_ERROR;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Moore outputs decoded from the next state so they register in step with it.
        case (state_d)
            S_COLLECT: begin
                ready_d = 1'b1;
                busy_d  = 1'b1;
            end
            S_WRITE: begin
                busy_d = 1'b1;
                wr_d   = 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                ready_d = 1'b1;
                busy_d  = 1'b1;
            end
`endif
            S_DONE: begin
                done_d     = 1'b1;
                core_rst_d = 1'b0;
            end
            S_ERROR: begin
                err_d = 1'b1;
            end
            default: begin
                ready_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset aborts any partial word.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            core_rst_q <= 1'b1;
            wr_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            core_rst_q <= core_rst_d;
            wr_q       <= wr_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running byte sum and error flag.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            csum_q <= '0;
            err_q  <= 1'b0;
        end else begin
            csum_q <= csum_d;
            err_q  <= err_d;
        end
    end

    assign bus.Err = err_q;
`else
    // Without the checksum there is no failure mode; the next-value is unused.
    logic unused_err;
    assign unused_err = err_d;
    assign bus.Err    = 1'b0;
`endif

    assign bus.Byte_Ready     = ready_q;
    assign bus.Busy           = busy_q;
    assign bus.Done           = done_q;
    assign bus.Core_Reset     = core_rst_q;
    assign bus.Ram_Inst_Write = wr_q;
    assign bus.Inst_Addr      = addr_q;
    assign bus.Ram_Inst_In    = data_q;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader (INST_WIDTH=16, NUM_MEM_ADDR=4).
// Expected RAM writes are queued as bytes are accepted and checked when the strobe fires.
module tb_inst_loader;

    logic Clk;
    logic Reset;

    inst_loader_if #(.INST_WIDTH(16), .ADDR_WIDTH(8)) bus ();

    inst_loader #(
        .INST_WIDTH  (16),
        .ADDR_WIDTH  (8),
        .NUM_MEM_ADDR(4)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t        exp_q[$];
    int         tests;
    int         errors;
    int         cycles;
    logic [7:0] pat[8];
    logic [7:0] sum;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one clock and sample #1 later; every write strobe is scored here.
    task automatic step();
        wr_t e;
        @(posedge Clk);
        #1;
        cycles++;
        if (bus.Ram_Inst_Write === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got addr=%h data=%h, none expected",
                         bus.Inst_Addr, bus.Ram_Inst_In);
            end else begin
                e = exp_q.pop_front();
                if (bus.Inst_Addr !== e.addr || bus.Ram_Inst_In !== e.data) begin
                    errors++;
                    $display("FAIL write got %h@%h, expected %h@%h",
                             bus.Ram_Inst_In, bus.Inst_Addr, e.data, e.addr);
                end
            end
        end
    endtask

    // Present one byte (after an optional idle gap) and hold it until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit last,
                             input logic [7:0] addr, input logic [15:0] word);
        bit got;
        int t;
        wr_t e;
        got = 1'b0;
        t   = 0;
        repeat (gap) step();
        bus.Byte_In    = b;
        bus.Byte_Valid = 1'b1;
        while (!got && t < 64) begin
            if (bus.Byte_Ready === 1'b1) begin
                if (last) begin
                    e.addr = addr;
                    e.data = word;
                    exp_q.push_back(e);
                end
                got = 1'b1;
            end
            step();
            t++;
        end
        bus.Byte_Valid = 1'b0;
        if (!got) begin
            tests++;
            errors++;
            $display("FAIL byte_timeout byte=%h not accepted within 64 cycles", b);
        end
    endtask

    // Send the first n bytes of pat, queueing each completed word.
    task automatic send_stream(input int n, input bit gapped);
        for (int i = 0; i < n; i++) begin
            send_byte(pat[i], gapped ? int'($urandom_range(0, 3)) : 0, (i % 2) == 1,
                      8'(i / 2), (i % 2 == 1) ? {pat[(i > 0) ? i - 1 : 0], pat[i]} : 16'h0);
        end
    endtask

    function automatic logic [7:0] pat_sum();
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < 8; i++) s = s + pat[i];
        return s;
    endfunction

    // Pulse Start and check the loader is busy and ready one cycle later.
    task automatic do_start();
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        tests++;
        if ({bus.Busy, bus.Byte_Ready, bus.Core_Reset, bus.Done, bus.Err, bus.Inst_Addr}
            !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL start got busy/rdy/crst/done/err/addr=%b%b%b%b%b/%h, expected 11100/00",
                     bus.Busy, bus.Byte_Ready, bus.Core_Reset, bus.Done, bus.Err, bus.Inst_Addr);
        end
    endtask

    // Complete a load (trailer when the checksum is built in) and check the end state.
    task automatic finish_load(input logic [7:0] trailer, input bit exp_ok);
        logic [3:0] exp_v;
`ifdef LOADER_CHECKSUM_EN
        send_byte(trailer, 0, 1'b0, 8'h00, 16'h0000);
        exp_v = exp_ok ? 4'b0100 : 4'b1010;
`else
        step();
        exp_v = (exp_ok || trailer == 8'h00) ? 4'b0100 : 4'b0100;
`endif
        tests++;
        if ({bus.Core_Reset, bus.Done, bus.Err, bus.Busy} !== exp_v) begin
            errors++;
            $display("FAIL load_end got crst/done/err/busy=%b, expected %b",
                     {bus.Core_Reset, bus.Done, bus.Err, bus.Busy}, exp_v);
        end
        tests++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_writes got %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic load_pattern(input bit gapped);
        do_start();
        send_stream(8, gapped);
        sum = pat_sum();
        finish_load(8'h00 - sum, 1'b1);
    endtask

    task automatic set_base_pattern();
        pat = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        #2 Reset = 1'b0;
        repeat (3) step();
        Reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            tests++;
            if ({bus.Core_Reset, bus.Ram_Inst_Write, bus.Inst_Addr, bus.Byte_Ready,
                 bus.Busy, bus.Done, bus.Err} !== {1'b1, 1'b0, 8'h00, 4'b0000}) begin
                errors++;
                $display("FAIL reset_idle cycle %0d got crst=%b wr=%b addr=%h rdy=%b busy=%b done=%b err=%b",
                         i, bus.Core_Reset, bus.Ram_Inst_Write, bus.Inst_Addr, bus.Byte_Ready,
                         bus.Busy, bus.Done, bus.Err);
            end
        end
    endtask

    // Continuous stream: 3 cycles per word, so 11 cycles from first ready to last write.
    task automatic test_back_to_back();
        set_base_pattern();
        do_start();
        cycles = 0;
        send_stream(8, 1'b0);
        tests++;
        if (cycles != 11) begin
            errors++;
            $display("FAIL throughput got %0d cycles, expected 11", cycles);
        end
        tests++;
        if (bus.Ram_Inst_Write !== 1'b1 || bus.Inst_Addr !== 8'h03) begin
            errors++;
            $display("FAIL last_write_latency got wr=%b addr=%h, expected 1/03",
                     bus.Ram_Inst_Write, bus.Inst_Addr);
        end
        sum = pat_sum();
        finish_load(8'h00 - sum, 1'b1);
    endtask

    task automatic test_gapped();
        set_base_pattern();
        load_pattern(1'b1);
    endtask

    task automatic test_reset_mid();
        set_base_pattern();
        do_start();
        send_stream(3, 1'b0);
        #2 Reset = 1'b0;
        #1;
        tests++;
        if ({bus.Core_Reset, bus.Ram_Inst_Write, bus.Inst_Addr, bus.Ram_Inst_In,
             bus.Byte_Ready, bus.Busy, bus.Done, bus.Err}
            !== {1'b1, 1'b0, 8'h00, 16'h0000, 4'b0000}) begin
            errors++;
            $display("FAIL reset_abort got crst=%b wr=%b addr=%h data=%h rdy=%b busy=%b",
                     bus.Core_Reset, bus.Ram_Inst_Write, bus.Inst_Addr, bus.Ram_Inst_In,
                     bus.Byte_Ready, bus.Busy);
        end
        repeat (3) step();
        Reset = 1'b1;
        repeat (2) step();
        tests++;
        if (bus.Core_Reset !== 1'b1 || bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset got crst=%b busy=%b, expected 1/0", bus.Core_Reset, bus.Busy);
        end
        load_pattern(1'b0);
    endtask

    task automatic test_restart();
        repeat (2) step();
        tests++;
        if (bus.Inst_Addr !== 8'h03 || bus.Done !== 1'b1) begin
            errors++;
            $display("FAIL done_hold got addr=%h done=%b, expected 03/1", bus.Inst_Addr, bus.Done);
        end
        pat = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};
        load_pattern(1'b1);
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        set_base_pattern();
        do_start();
        send_stream(8, 1'b0);
        finish_load(8'hC8, 1'b1);
        do_start();
        send_stream(8, 1'b1);
        finish_load(8'hC9, 1'b0);
        repeat (3) step();
        tests++;
        if (bus.Err !== 1'b1 || bus.Core_Reset !== 1'b1) begin
            errors++;
            $display("FAIL err_hold got err=%b crst=%b, expected 1/1", bus.Err, bus.Core_Reset);
        end
        do_start();
        send_stream(8, 1'b0);
        finish_load(8'hC8, 1'b1);
    endtask
`endif

    initial begin
        tests          = 0;
        errors         = 0;
        cycles         = 0;
        bus.Start      = 1'b0;
        bus.Byte_In    = 8'h00;
        bus.Byte_Valid = 1'b0;
        test_reset();
        test_back_to_back();
        test_gapped();
        test_reset_mid();
        test_restart();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish within 500000 time units");
        $fatal(1, "watchdog");
    end

endmodule
